// File: rtl/seq_num_adder.sv
// Sequential adder for unsigned fixed-point or small unbiased floats.
// Floats are aligned one bit per cycle, added, then normalised by at most one place.
module seq_num_adder #(
    parameter int MW = 4,
    parameter int EW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             format,
    input  logic [MW+EW-1:0] operand1,
    input  logic [MW+EW-1:0] operand2,
    output logic [MW+EW:0]   result,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int W  = MW + EW;
    localparam int CW = (EW > $clog2(MW + 2)) ? EW : $clog2(MW + 2);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t         state, state_next;
    logic           fmt_r;
    logic [W-1:0]   opa, opb;
    logic [MW:0]    ma, mb;
    logic [EW-1:0]  exp_r;
    logic [CW-1:0]  cnt;
    logic [MW+1:0]  sum;

    logic           accept;
    logic [MW-1:0]  f1, f2;
    logic [EW-1:0]  e1, e2, dexp, cap_exp;
    logic [MW:0]    cap_big, cap_small;
    logic [CW-1:0]  dext, cap_cnt;

    assign accept = start && (state == IDLE || state == DONE);

    // Larger-exponent mantissa goes to ma; only mb is ever shifted.
    always_comb begin
        f1 = operand1[W-1:EW];
        e1 = operand1[EW-1:0];
        f2 = operand2[W-1:EW];
        e2 = operand2[EW-1:0];
        if (e1 >= e2) begin
            cap_big   = {1'b1, f1};
            cap_small = {1'b1, f2};
            cap_exp   = e1;
            dexp      = e1 - e2;
        end else begin
            cap_big   = {1'b1, f2};
            cap_small = {1'b1, f1};
            cap_exp   = e2;
            dexp      = e2 - e1;
        end
        dext    = CW'(dexp);
        cap_cnt = (dext > CW'(MW + 1)) ? CW'(MW + 1) : dext;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (format && dexp != '0) state_next = ALIGN;
                    else                      state_next = ADD;
                end else begin
                    state_next = IDLE;
                end
            end
            ALIGN:   state_next = (cnt == CW'(1)) ? ADD : ALIGN;
            ADD:     state_next = fmt_r ? NORM : DONE;
            NORM:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ALIGN) || (state == ADD) || (state == NORM);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fmt_r  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            ma     <= '0;
            mb     <= '0;
            exp_r  <= '0;
            cnt    <= '0;
            sum    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) begin
                fmt_r <= format;
                opa   <= operand1;
                opb   <= operand2;
                ma    <= cap_big;
                mb    <= cap_small;
                exp_r <= cap_exp;
                cnt   <= cap_cnt;
            end
            case (state)
                ALIGN: begin
                    mb  <= mb >> 1;
                    cnt <= cnt - CW'(1);
                end
                ADD: begin
                    if (fmt_r) begin
                        sum <= {1'b0, ma} + {1'b0, mb};
                    end else begin
                        result <= {1'b0, opa} + {1'b0, opb};
                        ovf    <= 1'b0;
                    end
                end
                NORM: begin
                    if (sum[MW+1]) begin
                        if (&exp_r) begin
                            result <= {1'b0, {MW{1'b1}}, {EW{1'b1}}};
                            ovf    <= 1'b1;
                        end else begin
                            result <= {1'b0, sum[MW:1], exp_r + EW'(1)};
                            ovf    <= 1'b0;
                        end
                    end else begin
                        result <= {1'b0, sum[MW-1:0], exp_r};
                        ovf    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_num_adder.sv
// Scoreboard bench for seq_num_adder: driver pushes model results, monitor checks on done.
module tb_seq_num_adder;

    localparam int MW = 4;
    localparam int EW = 4;
    localparam int W  = MW + EW;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         format = 1'b0;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2 = '0;
    logic [W:0]   result;
    logic         busy, done, ovf;

    seq_num_adder #(.MW(MW), .EW(EW)) dut (
        .clk(clk), .rst(rst), .start(start), .format(format),
        .operand1(operand1), .operand2(operand2),
        .result(result), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] r;
        bit         o;
        int         t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: mantissas as integers with hidden one, shift by capped distance, renormalise.
    function automatic void model(input bit f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W:0] r, output bit o, output int lat);
        int ma, mb, ea, eb, tmp, d, sh, s, e;
        if (!f) begin
            r   = (W+1)'(int'(a) + int'(b));
            o   = 1'b0;
            lat = 1;
        end else begin
            ma = (1 << MW) + int'(a[W-1:EW]);
            ea = int'(a[EW-1:0]);
            mb = (1 << MW) + int'(b[W-1:EW]);
            eb = int'(b[EW-1:0]);
            if (ea < eb) begin
                tmp = ma; ma = mb; mb = tmp;
                tmp = ea; ea = eb; eb = tmp;
            end
            d  = ea - eb;
            sh = (d > MW + 1) ? MW + 1 : d;
            s  = ma + (mb >> sh);
            e  = ea;
            if (s >= (2 << MW)) begin
                s = s >> 1;
                e = e + 1;
            end
            if (e > (1 << EW) - 1) begin
                o = 1'b1;
                r = (W+1)'((1 << W) - 1);
            end else begin
                o = 1'b0;
                r = (W+1)'(((s - (1 << MW)) << EW) + e);
            end
            lat = sh + 2;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("ovf", 32'(ovf), 32'(e.o));
                chk("done_cycle", 32'(cyc), 32'(e.t));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the DONE cycle so the next op can chain.
    task automatic issue(input bit f, input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
        exp_t e;
        int   lat, k;
        model(f, a, b, e.r, e.o, lat);
        k   = cyc + 1;
        e.t = k + lat;
        q.push_back(e);
        start    = 1'b1;
        format   = f;
        operand1 = a;
        operand2 = b;
        @(negedge clk);
        while (cyc < k + lat) begin
            if (noisy) begin
                operand1 = W'($urandom);
                operand2 = W'($urandom);
                format   = 1'($urandom);
                start    = ($urandom_range(0, 2) == 0);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result", 32'(result), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_ovf", 32'(ovf), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, 8'hFF, 8'h01, 1'b0);
        issue(1'b1, 8'h03, 8'h03, 1'b0);
        issue(1'b1, 8'h84, 8'h02, 1'b0);
        issue(1'b1, 8'hFF, 8'hFF, 1'b0);
        issue(1'b1, 8'h0F, 8'h00, 1'b1);
        issue(1'b1, 8'h02, 8'h84, 1'b1);
        issue(1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);

        // Abort a long float op while it is aligning.
        start = 1'b1; format = 1'b1; operand1 = 8'h0F; operand2 = 8'h00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("align_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        chk("abort_result", 32'(result), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_ovf", 32'(ovf), 32'(0));
        repeat (8) @(negedge clk);
        issue(1'b1, 8'h84, 8'h02, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 3) == 0) b[EW-1:0] = a[EW-1:0];
            issue(1'($urandom), a, b, 1'($urandom));
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_num_adder.md
SEQ_NUM_ADDER -- requirements
Module: seq_num_adder

Interface
REQ-001 SHALL have parameter MW, default 4: float mantissa field width (hidden leading 1 not stored).
REQ-002 SHALL have parameter EW, default 4: float exponent field width, unsigned, unbiased; W = MW+EW.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only when accepting (IDLE or DONE).
REQ-006 SHALL have port format  input  1  0 = fixed-point unsigned add, 1 = float add; sampled with start.
REQ-007 SHALL have port operand1  input  W  first operand; float layout {mantissa[MW-1:0], exponent[EW-1:0]}.
REQ-008 SHALL have port operand2  input  W  second operand, same layout.
REQ-009 SHALL have port result  output  W+1  sum; fixed = full W+1-bit sum; float = {1'b0, mantissa, exponent}.
REQ-010 SHALL have port busy  output  1  high in ALIGN, ADD, NORM.
REQ-011 SHALL have port done  output  1  single-cycle pulse; result valid.
REQ-012 SHALL have port ovf  output  1  float exponent overflow on this result; valid with done.

Function
REQ-013 SHALL implement states IDLE, ALIGN, ADD, NORM, DONE.
REQ-014 SHALL capture operands and format at edge k when start=1 in IDLE or DONE; start in ALIGN/ADD/NORM SHALL be ignored.
REQ-015 Fixed mode: capture -> ADD; edge k+1 loads result = operand1+operand2 (W+1 bits, no loss), ovf=0 -> DONE; done high in cycle after edge k+1.
REQ-016 Float mode: capture extends mantissas to {1, field} (MW+1 bits), computes d = |exp1-exp2|, selects larger exponent; d=0 -> ADD, else -> ALIGN.
REQ-017 ALIGN: SHALL right-shift the smaller-exponent mantissa one bit per cycle, truncating; ALIGN cycles = min(d, MW+1); then -> ADD.
REQ-018 ADD: SHALL form MW+2-bit sum of aligned mantissas -> NORM.
REQ-019 NORM: if sum[MW+1]=1, shift right one (truncate), exponent+1; else unchanged; result mantissa = bits below leading 1 -> DONE.
REQ-020 Exponent increment past 2^EW-1 SHALL set ovf=1 and saturate result to mantissa all-ones, exponent all-ones.
REQ-021 Float done SHALL assert in cycle after edge k+min(d,MW+1)+2.
REQ-022 DONE lasts exactly one cycle; next state IDLE, or new capture if start=1 (back-to-back, busy stays low in DONE).
REQ-023 result and ovf SHALL hold last value until next result load; no rounding other than truncation.
REQ-024 Operand input changes after capture SHALL not affect the operation in progress.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, result=0, busy=0, done=0, ovf=0, clear internal registers; overrides start.
REQ-026 Reset mid-operation SHALL abort it; no done pulse for the aborted request.

Verification (MW=4, EW=4)
REQ-027 fixed, op1=0xFF, op2=0x01 -> result=0x100, ovf=0, done one cycle after edge k+1.
REQ-028 float, op1=0x03, op2=0x03 -> 1.0000+1.0000 normalises -> result=0x004, ovf=0, done after edge k+2.
REQ-029 float, op1=0x84, op2=0x02 -> d=2, two ALIGN cycles -> result=0x0C4, done after edge k+4.
REQ-030 float, op1=0xFF, op2=0xFF -> carry at exp 15 -> ovf=1, result=0x0FF.
REQ-031 float, op1=0x0F, op2=0x00 -> d=15 capped to 5 ALIGN cycles -> result=0x00F, done after edge k+7; start pulsed during ALIGN ignored.
REQ-032 rst asserted during ALIGN -> next cycle all outputs 0, no done; new start after reset completes normally.
